bram_tdp: RTL and testbench
===========================

Name: bram_tdp

Overview:
- Parametrised true dual-port block RAM; successor to the single-port 1024x32 inferred BRAM.
- Two independent read/write ports A and B share one array on one clock.
- Adds per-byte write enables, a per-port write mode, a selectable 1- or 2-cycle read latency with a valid strobe, out-of-range address handling, and defined collision rules.
- Used as the local buffer between the memcpy AXI master engine and its register/stream side.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
RAM_SIZE, 1024, number of words; any value from 2 to 2**ADDR_WIDTH
ADDR_WIDTH, 10, address width in bits
READ_LATENCY, 1, 1 = array output only; 2 = extra output register stage
WRITE_MODE_A, 0, port A mode: 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE
WRITE_MODE_B, 0, port B mode, same encoding as WRITE_MODE_A

Ports:
clk  in  1  single clock for both ports
rst_n  in  1  asynchronous, active-low reset
a_en  in  1  port A access enable
a_we  in  DATA_WIDTH/8  port A byte write enables; bit i covers data bits [8i+7:8i]
a_addr  in  ADDR_WIDTH  port A word address
a_din  in  DATA_WIDTH  port A write data
a_dout  out  DATA_WIDTH  port A read data
a_valid  out  1  port A read data valid strobe
b_en, b_we, b_addr, b_din, b_dout, b_valid: same as the port A signals, for port B

Behaviour:
- Reset (rst_n low, async assert, sync release): a_dout, b_dout, a_valid, b_valid = 0; all pipeline registers = 0; array contents untouched.
- Access: x_en=1 at edge k. Write bytes = bits where x_we=1. x_we all zero = pure read.
- Write: at edge k, each enabled byte of RAM[addr] takes the matching byte of x_din; other bytes are kept.
- Read data source:
  - pure read: RAM[addr] before edge k.
  - WRITE_FIRST with write: merged word (new bytes where x_we set, old bytes elsewhere).
  - READ_FIRST with write: old word.
  - NO_CHANGE with write: x_dout holds; x_valid is not asserted for that access.
- Latency:
  - READ_LATENCY=1: data on x_dout after edge k; x_valid=1 for one cycle after edge k.
  - READ_LATENCY=2: both delayed one more edge.
  - x_dout holds its last value when there is no new valid access.
  - Back-to-back accesses give one result per cycle (fully pipelined).
- Idle: x_en=0 means no array access and x_valid=0 for that slot; x_we is ignored.
- Out of range (addr >= RAM_SIZE): write discarded; read returns 0 with x_valid still asserted.
- Cross-port collisions, same address, same edge:
  - both writing: byte-wise, port A wins on bytes both enable; bytes enabled by only one port take that port's data.
  - one reads, the other writes: the reader gets the old word, regardless of its own mode.
- Reset mid-operation: in-flight pipeline results are discarded; no x_valid after reset release until a new access.
- Elaboration checks: DATA_WIDTH%8 != 0, READ_LATENCY not in {1,2}, RAM_SIZE > 2**ADDR_WIDTH, or write mode > 2 raise a fatal error.

Optional Feature:
- Macro BRAM_COLLISION_FLAG_EN.
- Defined: adds output port collision (1 bit, reset 0). It pulses high one cycle after any edge where both ports are enabled on the same in-range address and at least one of them writes. Aligned with READ_LATENCY=1 timing irrespective of READ_LATENCY.
- Undefined: no port is added and there is no logic; array behaviour is identical in both builds.

Decomposition:
- Package bram_pkg:
  - write mode constants WM_WRITE_FIRST=0, WM_READ_FIRST=1, WM_NO_CHANGE=2;
  - function nb_col(width) returning width/8;
  - function to merge a word under a byte mask.
- Sub-module bram_tdp_port, instantiated once per port: mode mux, valid generation, optional second output stage. The shared array and collision logic stay in bram_tdp.

Test Plan:
- Reset then A write 0xDEADBEEF @5, A read @5 (latency 1) -> a_dout=0xDEADBEEF, a_valid high exactly one cycle after the read edge.
- A write 0xAABBCCDD @7 (we=0xF), then A write 0x11223344 @7 with we=0x5 in WRITE_FIRST -> a_dout=0xAA22CC44; same in READ_FIRST -> 0xAABBCCDD; NO_CHANGE -> a_dout unchanged, a_valid=0.
- Same edge: A writes 0x1111_1111 we=0x3, B writes 0x2222_2222 we=0xE, both @9; then read @9 -> 0x2222_1111; with the macro defined, collision=1 for one cycle.
- B reads @9 while A writes 0x5 @9 (@9 previously 0x2222_1111) -> b_dout=0x2222_1111; next B read @9 -> 0x00000005.
- READ_LATENCY=2, streaming reads @0..@3 -> four consecutive valid cycles starting two edges after the first read, data in order; read @1030 with RAM_SIZE=1024 -> 0 with valid.
- Assert rst_n low one cycle after a read at READ_LATENCY=2 -> no valid pulse, dout=0; array content preserved and readable after release.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the true dual-port block RAM.
// Contents: write mode encodings, byte-lane count helper, byte-mask merge helper.
package bram_pkg;

  localparam int unsigned WM_WRITE_FIRST = 0;
  localparam int unsigned WM_READ_FIRST  = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  // Widest word the merge helper handles; callers cast to/from their width.
  localparam int unsigned MAX_DW = 1024;
  localparam int unsigned MAX_NB = MAX_DW / 8;

  // Number of byte lanes in a word of the given width.
  function automatic int unsigned nb_col(input int unsigned width);
    return width / 8;
  endfunction

  // Replace the bytes of old_w selected by mask with the bytes of new_w.
  function automatic logic [MAX_DW-1:0] merge_bytes(input logic [MAX_DW-1:0] old_w,
                                                    input logic [MAX_DW-1:0] new_w,
                                                    input logic [MAX_NB-1:0] mask);
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(MAX_NB); i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_tdp_port.sv
// Per-port read path: selects read data by write mode, generates the valid
// strobe and optionally adds a second output register stage.
// Ports: clk, rst_n; en_i access enable; wr_i access writes at least one byte;
//        old_i word before the edge (0 when out of range); new_i word merged
//        with this port's write data (0 when out of range);
//        dout_o read data; valid_o read data valid strobe.
module bram_tdp_port
  import bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WRITE_MODE   = WM_WRITE_FIRST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] old_i,
  input  logic [DATA_WIDTH-1:0] new_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  valid_o
);

  logic                  s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_d;
  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  // Read data source selection by write mode.
  always_comb begin
    s1_valid_d = en_i;
    s1_data_d  = old_i;
    if (en_i && wr_i) begin
      case (WRITE_MODE)
        WM_WRITE_FIRST: s1_data_d  = new_i;
        WM_NO_CHANGE:   s1_valid_d = 1'b0;
        default:        s1_data_d  = old_i;
      endcase
    end
  end

  // First output stage; data only moves on a valid access so dout holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_valid_d) s1_data_q <= s1_data_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    // Second output stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign dout_o  = s2_data_q;
    assign valid_o = s2_valid_q;
  end else begin : g_lat1
    assign dout_o  = s1_data_q;
    assign valid_o = s1_valid_q;
  end

endmodule

// File: rtl/bram_tdp.sv
// True dual-port block RAM with byte write enables, per-port write modes,
// 1- or 2-cycle read latency and defined same-address collision rules.
// Optional macro BRAM_COLLISION_FLAG_EN adds the collision output.
// Ports: clk, rst_n (async active-low);
//        a_en/a_we/a_addr/a_din in, a_dout/a_valid out (port A);
//        b_en/b_we/b_addr/b_din in, b_dout/b_valid out (port B);
//        collision out (only with BRAM_COLLISION_FLAG_EN).
module bram_tdp
  import bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RAM_SIZE     = 1024,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WRITE_MODE_A = WM_WRITE_FIRST,
  parameter int unsigned WRITE_MODE_B = WM_WRITE_FIRST
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            a_en,
  input  logic [nb_col(DATA_WIDTH)-1:0]   a_we,
  input  logic [ADDR_WIDTH-1:0]           a_addr,
  input  logic [DATA_WIDTH-1:0]           a_din,
  output logic [DATA_WIDTH-1:0]           a_dout,
  output logic                            a_valid,
  input  logic                            b_en,
  input  logic [nb_col(DATA_WIDTH)-1:0]   b_we,
  input  logic [ADDR_WIDTH-1:0]           b_addr,
  input  logic [DATA_WIDTH-1:0]           b_din,
  output logic [DATA_WIDTH-1:0]           b_dout,
  output logic                            b_valid
`ifdef BRAM_COLLISION_FLAG_EN
  ,
  output logic                            collision
`endif
);

  localparam int unsigned NB    = nb_col(DATA_WIDTH);
  localparam int unsigned IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] RAM_LIM = (ADDR_WIDTH+1)'(RAM_SIZE);

  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DW) begin : g_err_dw
    $fatal(1, "bram_tdp: DATA_WIDTH must be a multiple of 8 and at most MAX_DW");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_err_rl
    $fatal(1, "bram_tdp: READ_LATENCY must be 1 or 2");
  end
  if (RAM_SIZE < 2 || RAM_SIZE > (1 << ADDR_WIDTH)) begin : g_err_rs
    $fatal(1, "bram_tdp: RAM_SIZE must be in 2..2**ADDR_WIDTH");
  end
  if (WRITE_MODE_A > 2 || WRITE_MODE_B > 2) begin : g_err_wm
    $fatal(1, "bram_tdp: write mode must be 0, 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem_q [RAM_SIZE];

  logic                  a_inr_c, b_inr_c, same_c;
  logic                  a_wr_c, b_wr_c;       // access writes some byte
  logic                  a_wmem_c, b_wmem_c;   // array actually written
  logic [DATA_WIDTH-1:0] a_old_c, b_old_c;
  logic [DATA_WIDTH-1:0] a_new_c, b_new_c;
  logic [DATA_WIDTH-1:0] a_wdata_c;

  // Address decode, old-word read and merged write words.
  always_comb begin
    a_inr_c  = {1'b0, a_addr} < RAM_LIM;
    b_inr_c  = {1'b0, b_addr} < RAM_LIM;
    same_c   = a_addr == b_addr;
    a_wr_c   = a_en && (|a_we);
    b_wr_c   = b_en && (|b_we);
    a_wmem_c = a_wr_c && a_inr_c;
    b_wmem_c = b_wr_c && b_inr_c;
    a_old_c  = a_inr_c ? mem_q[IDX_W'(a_addr)] : '0;
    b_old_c  = b_inr_c ? mem_q[IDX_W'(b_addr)] : '0;
    a_new_c  = a_inr_c ? DATA_WIDTH'(merge_bytes(MAX_DW'(a_old_c), MAX_DW'(a_din), MAX_NB'(a_we))) : '0;
    b_new_c  = b_inr_c ? DATA_WIDTH'(merge_bytes(MAX_DW'(b_old_c), MAX_DW'(b_din), MAX_NB'(b_we))) : '0;
    // Both ports write one word: layer A's bytes over B's so A wins shared lanes.
    a_wdata_c = (b_wmem_c && same_c)
              ? DATA_WIDTH'(merge_bytes(MAX_DW'(b_new_c), MAX_DW'(a_din), MAX_NB'(a_we)))
              : a_new_c;
  end

  // Shared array; contents are not reset.
  always_ff @(posedge clk) begin
    if (a_wmem_c) mem_q[IDX_W'(a_addr)] <= a_wdata_c;
    if (b_wmem_c && !(a_wmem_c && same_c)) mem_q[IDX_W'(b_addr)] <= b_new_c;
  end

  bram_tdp_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .WRITE_MODE  (WRITE_MODE_A)
  ) u_port_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (a_en),
    .wr_i   (a_wr_c),
    .old_i  (a_old_c),
    .new_i  (a_new_c),
    .dout_o (a_dout),
    .valid_o(a_valid)
  );

  bram_tdp_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .WRITE_MODE  (WRITE_MODE_B)
  ) u_port_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (b_en),
    .wr_i   (b_wr_c),
    .old_i  (b_old_c),
    .new_i  (b_new_c),
    .dout_o (b_dout),
    .valid_o(b_valid)
  );

`ifdef BRAM_COLLISION_FLAG_EN
  logic collision_d, collision_q;

  // Same in-range word touched by both ports with at least one writer.
  always_comb begin
    collision_d = a_en && b_en && a_inr_c && same_c && (a_wr_c || b_wr_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision_q <= 1'b0;
    else        collision_q <= collision_d;
  end

  assign collision = collision_q;
`endif

endmodule

// File: tb/tb_bram_tdp.sv
module tb_bram_tdp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // dut0: latency 1, A WRITE_FIRST, B READ_FIRST, 1000 words in a 10-bit space
  logic        a_en0, b_en0;
  logic [3:0]  a_we0, b_we0;
  logic [9:0]  a_addr0, b_addr0;
  logic [31:0] a_din0, b_din0, a_dout0, b_dout0;
  logic        a_valid0, b_valid0, coll0;

  // dut1: latency 2, A NO_CHANGE, B WRITE_FIRST, 1024 words in an 11-bit space
  logic        a_en1, b_en1;
  logic [3:0]  a_we1, b_we1;
  logic [10:0] a_addr1, b_addr1;
  logic [31:0] a_din1, b_din1, a_dout1, b_dout1;
  logic        a_valid1, b_valid1, coll1;

  bram_tdp #(.DATA_WIDTH(32), .RAM_SIZE(1000), .ADDR_WIDTH(10), .READ_LATENCY(1),
             .WRITE_MODE_A(0), .WRITE_MODE_B(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en0), .a_we(a_we0), .a_addr(a_addr0), .a_din(a_din0),
    .a_dout(a_dout0), .a_valid(a_valid0),
    .b_en(b_en0), .b_we(b_we0), .b_addr(b_addr0), .b_din(b_din0),
    .b_dout(b_dout0), .b_valid(b_valid0)
`ifdef BRAM_COLLISION_FLAG_EN
    , .collision(coll0)
`endif
  );

  bram_tdp #(.DATA_WIDTH(32), .RAM_SIZE(1024), .ADDR_WIDTH(11), .READ_LATENCY(2),
             .WRITE_MODE_A(2), .WRITE_MODE_B(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en1), .a_we(a_we1), .a_addr(a_addr1), .a_din(a_din1),
    .a_dout(a_dout1), .a_valid(a_valid1),
    .b_en(b_en1), .b_we(b_we1), .b_addr(b_addr1), .b_din(b_din1),
    .b_dout(b_dout1), .b_valid(b_valid1)
`ifdef BRAM_COLLISION_FLAG_EN
    , .collision(coll1)
`endif
  );

`ifndef BRAM_COLLISION_FLAG_EN
  assign coll0 = 1'b0;
  assign coll1 = 1'b0;
`endif

  typedef struct {
    logic        a_en;
    logic [3:0]  a_we;
    logic [9:0]  a_addr;
    logic [31:0] a_din;
    logic        b_en;
    logic [3:0]  b_we;
    logic [9:0]  b_addr;
    logic [31:0] b_din;
    logic        ea_v;
    logic [31:0] ea_d;
    logic        eb_v;
    logic [31:0] eb_d;
    logic        ec;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    a_en1 = 1'b0; a_we1 = 4'h0; a_addr1 = '0; a_din1 = '0;
    b_en1 = 1'b0; b_we1 = 4'h0; b_addr1 = '0; b_din1 = '0;
  endtask

  initial begin
    // a_en a_we a_addr a_din | b_en b_we b_addr b_din | ea_v ea_d | eb_v eb_d | ec
    vecs[0]  = '{1, 4'hF, 10'd5,    32'hDEADBEEF, 0, 4'h0, 10'd0,   32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        0};
    vecs[1]  = '{1, 4'h0, 10'd5,    32'h0,        0, 4'h0, 10'd0,   32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        0};
    vecs[2]  = '{0, 4'h0, 10'd0,    32'h0,        0, 4'h0, 10'd0,   32'h0,        0, 32'hDEADBEEF, 0, 32'h0,        0};
    vecs[3]  = '{1, 4'hF, 10'd7,    32'hAABBCCDD, 0, 4'h0, 10'd0,   32'h0,        1, 32'hAABBCCDD, 0, 32'h0,        0};
    vecs[4]  = '{1, 4'h5, 10'd7,    32'h11223344, 0, 4'h0, 10'd0,   32'h0,        1, 32'hAA22CC44, 0, 32'h0,        0};
    vecs[5]  = '{1, 4'hF, 10'd8,    32'hAABBCCDD, 0, 4'h0, 10'd0,   32'h0,        1, 32'hAABBCCDD, 0, 32'h0,        0};
    vecs[6]  = '{0, 4'h0, 10'd0,    32'h0,        1, 4'h5, 10'd8,   32'h11223344, 0, 32'hAABBCCDD, 1, 32'hAABBCCDD, 0};
    vecs[7]  = '{0, 4'h0, 10'd0,    32'h0,        1, 4'h0, 10'd8,   32'h0,        0, 32'hAABBCCDD, 1, 32'hAA22CC44, 0};
    vecs[8]  = '{1, 4'hF, 10'd9,    32'h0,        0, 4'h0, 10'd0,   32'h0,        1, 32'h00000000, 0, 32'hAA22CC44, 0};
    vecs[9]  = '{1, 4'h3, 10'd9,    32'h11111111, 1, 4'hE, 10'd9,   32'h22222222, 1, 32'h00001111, 1, 32'h00000000, 1};
    vecs[10] = '{1, 4'h0, 10'd9,    32'h0,        1, 4'h0, 10'd9,   32'h0,        1, 32'h22221111, 1, 32'h22221111, 0};
    vecs[11] = '{1, 4'hF, 10'd9,    32'h5,        1, 4'h0, 10'd9,   32'h0,        1, 32'h00000005, 1, 32'h22221111, 1};
    vecs[12] = '{0, 4'h0, 10'd0,    32'h0,        1, 4'h0, 10'd9,   32'h0,        0, 32'h00000005, 1, 32'h00000005, 0};
    vecs[13] = '{1, 4'hF, 10'd1000, 32'hFFFFFFFF, 1, 4'h0, 10'd1000, 32'h0,       1, 32'h00000000, 1, 32'h00000000, 0};
    vecs[14] = '{1, 4'h0, 10'd1000, 32'h0,        0, 4'h0, 10'd0,   32'h0,        1, 32'h00000000, 0, 32'h00000000, 0};
    vecs[15] = '{0, 4'hF, 10'd5,    32'h0,        0, 4'hF, 10'd7,   32'h0,        0, 32'h00000000, 0, 32'h00000000, 0};
    vecs[16] = '{1, 4'h0, 10'd5,    32'h0,        1, 4'h0, 10'd7,   32'h0,        1, 32'hDEADBEEF, 1, 32'hAA22CC44, 0};
    vecs[17] = '{1, 4'hF, 10'd999,  32'h12345678, 0, 4'h0, 10'd0,   32'h0,        1, 32'h12345678, 0, 32'hAA22CC44, 0};
    vecs[18] = '{0, 4'h0, 10'd0,    32'h0,        1, 4'h0, 10'd999, 32'h0,        0, 32'h12345678, 1, 32'h12345678, 0};
    vecs[19] = '{1, 4'h0, 10'd5,    32'h0,        1, 4'hF, 10'd5,   32'h9,        1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1};
    vecs[20] = '{1, 4'h0, 10'd5,    32'h0,        0, 4'h0, 10'd0,   32'h0,        1, 32'h00000009, 0, 32'hDEADBEEF, 0};

    a_en0 = 0; a_we0 = 0; a_addr0 = 0; a_din0 = 0;
    b_en0 = 0; b_we0 = 0; b_addr0 = 0; b_din0 = 0;
    idle1();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst a_dout0", a_dout0, 32'h0);
    chk("rst a_valid0", 32'(a_valid0), 32'h0);
    chk("rst b_dout0", b_dout0, 32'h0);
    chk("rst b_valid0", 32'(b_valid0), 32'h0);
    chk("rst a_dout1", a_dout1, 32'h0);
    chk("rst a_valid1", 32'(a_valid1), 32'h0);
`ifdef BRAM_COLLISION_FLAG_EN
    chk("rst collision", 32'(coll0), 32'h0);
`endif

    // Table: one access per cycle on dut0, outputs checked just after the edge.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_en0 = vecs[i].a_en; a_we0 = vecs[i].a_we; a_addr0 = vecs[i].a_addr; a_din0 = vecs[i].a_din;
      b_en0 = vecs[i].b_en; b_we0 = vecs[i].b_we; b_addr0 = vecs[i].b_addr; b_din0 = vecs[i].b_din;
      cyc();
      chk($sformatf("v%0d a_valid", i), 32'(a_valid0), 32'(vecs[i].ea_v));
      chk($sformatf("v%0d a_dout", i), a_dout0, vecs[i].ea_d);
      chk($sformatf("v%0d b_valid", i), 32'(b_valid0), 32'(vecs[i].eb_v));
      chk($sformatf("v%0d b_dout", i), b_dout0, vecs[i].eb_d);
`ifdef BRAM_COLLISION_FLAG_EN
      chk($sformatf("v%0d collision", i), 32'(coll0), 32'(vecs[i].ec));
`endif
    end
    @(negedge clk);
    a_en0 = 0; a_we0 = 0; b_en0 = 0; b_we0 = 0;

    // dut1: fill words 0..3 through port B.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_en1 = 1'b1; b_we1 = 4'hF; b_addr1 = 11'(i); b_din1 = 32'h100 + 32'(i);
    end
    @(negedge clk);
    idle1();
    cyc();
    cyc();
    chk("lat2 b_dout WF", b_dout1, 32'h103);

    // Streaming reads at latency 2: results two edges after each read edge.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_en1 = (c < 4); a_we1 = 4'h0; a_addr1 = 11'(c);
      cyc();
      chk($sformatf("stream c%0d a_valid", c), 32'(a_valid1), (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
      chk($sformatf("stream c%0d a_dout", c), a_dout1,
          (c == 0) ? 32'h0 : ((c >= 5) ? 32'h103 : 32'h100 + 32'(c - 1)));
    end

    // NO_CHANGE write: dout holds, no valid.
    @(negedge clk);
    a_en1 = 1'b1; a_we1 = 4'hF; a_addr1 = 11'd0; a_din1 = 32'hCAFEF00D;
    @(negedge clk);
    idle1();
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk($sformatf("nc c%0d a_valid", c), 32'(a_valid1), 32'h0);
      chk($sformatf("nc c%0d a_dout", c), a_dout1, 32'h103);
    end
    @(negedge clk);
    a_en1 = 1'b1; a_we1 = 4'h0; a_addr1 = 11'd0;
    cyc();
    chk("nc rd e0 a_valid", 32'(a_valid1), 32'h0);
    @(negedge clk);
    idle1();
    cyc();
    chk("nc rd e1 a_valid", 32'(a_valid1), 32'h1);
    chk("nc rd e1 a_dout", a_dout1, 32'hCAFEF00D);
    cyc();
    chk("nc rd e2 a_valid", 32'(a_valid1), 32'h0);

    // Out-of-range read returns zero with valid.
    @(negedge clk);
    a_en1 = 1'b1; a_we1 = 4'h0; a_addr1 = 11'd1030;
    cyc();
    chk("oor e0 a_dout", a_dout1, 32'hCAFEF00D);
    @(negedge clk);
    idle1();
    cyc();
    chk("oor e1 a_valid", 32'(a_valid1), 32'h1);
    chk("oor e1 a_dout", a_dout1, 32'h0);

    // Reset while a read is in flight.
    @(negedge clk);
    a_en1 = 1'b1; a_we1 = 4'h0; a_addr1 = 11'd1;
    @(negedge clk);
    idle1();
    rst_n = 1'b0;
    #1;
    chk("rst mid a_dout", a_dout1, 32'h0);
    chk("rst mid a_valid", 32'(a_valid1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk($sformatf("post rst c%0d a_valid", c), 32'(a_valid1), 32'h0);
      chk($sformatf("post rst c%0d a_dout", c), a_dout1, 32'h0);
    end
    @(negedge clk);
    a_en1 = 1'b1; a_we1 = 4'h0; a_addr1 = 11'd1;
    @(negedge clk);
    idle1();
    cyc();
    chk("post rst rd a_valid", 32'(a_valid1), 32'h1);
    chk("post rst rd a_dout", a_dout1, 32'h101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
